// File: rtl/float_to_fixed_if.sv
// float_to_fixed_if: request/response channels of the float-to-fixed converter.
//   Request : in_valid, in_ready, float_in[31:0], fixpointpos[4:0]
//   Response: out_valid, out_ready, result[31:0], overflow, inexact, invalid
//   master : producer of floats / consumer of results (testbench, upstream logic)
//   slave  : the converter itself
interface float_to_fixed_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] float_in;
  logic [4:0]  fixpointpos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        inexact;
  logic        invalid;

  modport master (
    output in_valid, float_in, fixpointpos, out_ready,
    input  in_ready, out_valid, result, overflow, inexact, invalid
  );

  modport slave (
    input  in_valid, float_in, fixpointpos, out_ready,
    output in_ready, out_valid, result, overflow, inexact, invalid
  );
endinterface

// File: rtl/float_to_fixed.sv
// float_to_fixed: multi-cycle IEEE-754 single -> 32-bit two's-complement fixed point.
//   Computes trunc(float_in * 2^fixpointpos), shifting the significand one bit per cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : float_to_fixed_if.slave (request: in_valid/in_ready/float_in/fixpointpos,
//          response: out_valid/out_ready/result/overflow/inexact/invalid)
//   SAT_EN : 1 saturates on overflow (+ -> 0x7FFFFFFF, - -> 0x80000000), 0 returns 0.
module float_to_fixed #(
  parameter bit SAT_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  float_to_fixed_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SHIFT,
    S_PACK,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Captured operands, held for the whole conversion
  logic [31:0] f_reg;
  logic [4:0]  fp_reg;

  // Working datapath
  logic [31:0] mag;
  logic [4:0]  cnt;
  logic        shl;
  logic        w_ovf, w_inx, w_inv;

  // Registered outputs
  logic [31:0] res_r;
  logic        ovf_r, inx_r, inv_r;

  logic accept;
  assign accept = bus.in_valid && bus.in_ready;

  // ---------------------------------------------------------------- decode
  logic [7:0]         exp_f;
  logic [22:0]        mant_f;
  logic signed [10:0] sh;
  logic [4:0]         sh_cnt;
  logic               is_nan, is_inf, is_zero, too_big, too_small, skip_shift;

  assign exp_f  = f_reg[30:23];
  assign mant_f = f_reg[22:0];
  // sh = E - 127 + fp - 23
  assign sh     = $signed({3'b000, exp_f}) + $signed({6'b000000, fp_reg}) - 11'sd150;
  // Only used when -24 <= sh <= 8, so the low five bits carry |sh|
  assign sh_cnt = sh[10] ? (~sh[4:0] + 5'd1) : sh[4:0];

  assign is_nan    = (exp_f == 8'hFF) && (mant_f != '0);
  assign is_inf    = (exp_f == 8'hFF) && (mant_f == '0);
  assign is_zero   = (exp_f == 8'h00);
  assign too_big   = (sh > 11'sd8);
  assign too_small = (sh < -11'sd24);
  assign skip_shift = (exp_f == 8'hFF) || is_zero || too_big || too_small || (sh_cnt == 5'd0);

  // ------------------------------------------------------------------ pack
  logic        sign;
  logic        pos_ovf, neg_ovf;
  logic [31:0] pack_res;
  logic        pack_ovf, pack_inx, pack_inv;

  assign sign    = f_reg[31];
  assign pos_ovf = !sign && mag[31];
  assign neg_ovf = sign && (mag > 32'h8000_0000);

  always_comb begin
    pack_res = '0;
    pack_ovf = 1'b0;
    pack_inx = 1'b0;
    pack_inv = 1'b0;
    if (w_inv) begin
      pack_inv = 1'b1;
    end else if (w_ovf || pos_ovf || neg_ovf) begin
      // Overflow reports no inexact, even if bits were shifted out
      pack_ovf = 1'b1;
      if (SAT_EN)
        pack_res = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      pack_inx = w_inx;
      pack_res = sign ? (~mag + 32'd1) : mag;
    end
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_DECODE;
      S_DECODE: state_nxt = skip_shift ? S_PACK : S_SHIFT;
      S_SHIFT:  if (cnt == 5'd1) state_nxt = S_PACK;
      S_PACK:   state_nxt = S_DONE;
      S_DONE:   if (bus.out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_reg  <= '0;
      fp_reg <= '0;
      mag    <= '0;
      cnt    <= '0;
      shl    <= 1'b0;
      w_ovf  <= 1'b0;
      w_inx  <= 1'b0;
      w_inv  <= 1'b0;
      res_r  <= '0;
      ovf_r  <= 1'b0;
      inx_r  <= 1'b0;
      inv_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            f_reg  <= bus.float_in;
            fp_reg <= bus.fixpointpos;
          end
        end
        S_DECODE: begin
          w_ovf <= 1'b0;
          w_inx <= 1'b0;
          w_inv <= 1'b0;
          mag   <= '0;
          cnt   <= '0;
          shl   <= 1'b0;
          if (is_nan)
            w_inv <= 1'b1;
          else if (is_inf)
            w_ovf <= 1'b1;
          else if (is_zero)
            w_inx <= (mant_f != '0);   // denormals flush to zero
          else if (too_big)
            w_ovf <= 1'b1;
          else if (too_small)
            w_inx <= 1'b1;             // whole significand is below the LSB
          else begin
            mag <= {8'h00, 1'b1, mant_f};
            cnt <= sh_cnt;
            shl <= !sh[10];
          end
        end
        S_SHIFT: begin
          if (shl) begin
            mag <= mag << 1;
          end else begin
            mag   <= mag >> 1;
            w_inx <= w_inx | mag[0];
          end
          cnt <= cnt - 5'd1;
        end
        S_PACK: begin
          res_r <= pack_res;
          ovf_r <= pack_ovf;
          inx_r <= pack_inx;
          inv_r <= pack_inv;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------- outputs
  // in_ready stays low while reset is asserted
  assign bus.in_ready  = rst && (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = res_r;
  assign bus.overflow  = ovf_r;
  assign bus.inexact   = inx_r;
  assign bus.invalid   = inv_r;

endmodule

// File: tb/tb_float_to_fixed.sv
module tb_float_to_fixed;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  float_to_fixed_if bus ();
  float_to_fixed_if bus0 ();

  float_to_fixed #(.SAT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  float_to_fixed #(.SAT_EN(1'b0)) dut_nosat (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  typedef struct {
    logic [31:0] f;
    logic [4:0]  fp;
    logic [31:0] res;
    logic        ovf;
    logic        inx;
    logic        inv;
    int          lat;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];
  vec_t sbq [$];
  vec_t mon_e;

  int checks = 0;
  int fails  = 0;

  function automatic vec_t mk(input logic [31:0] f, input logic [4:0] fp,
                              input logic [31:0] res, input logic ovf,
                              input logic inx, input logic inv, input int lat);
    vec_t v;
    v.f = f; v.fp = fp; v.res = res; v.ovf = ovf; v.inx = inx; v.inv = inv; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard consumer: compare on every output transfer
  always @(posedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_output: got result %0h with empty scoreboard", bus.result);
      end else begin
        mon_e = sbq.pop_front();
        check($sformatf("result[%h fp=%0d]", mon_e.f, mon_e.fp), bus.result, mon_e.res);
        check($sformatf("flags ovf/inx/inv[%h fp=%0d]", mon_e.f, mon_e.fp),
              {bus.overflow, bus.inexact, bus.invalid}, {mon_e.ovf, mon_e.inx, mon_e.inv});
      end
    end
  end

  // Called at a negedge; returns just after the accept edge (+1)
  task automatic start(input vec_t v, input bit push);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", bus.in_ready, 1);
    bus.float_in    = v.f;
    bus.fixpointpos = v.fp;
    bus.in_valid    = 1'b1;
    @(posedge clk);
    if (push) sbq.push_back(v);
    #1;
    bus.in_valid    = 1'b0;
    bus.float_in    = 32'hFFFF_FFFF;   // captured operands must be held internally
    bus.fixpointpos = 5'd17;
  endtask

  // Counts edges from the accept edge (counted as 1) until out_valid is seen
  task automatic wait_valid(output int n);
    n = 1;
    @(negedge clk);
    while (!bus.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_within_bound", bus.out_valid, 1);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic send(input vec_t v);
    int n;
    start(v, 1'b1);
    wait_valid(n);
    check($sformatf("latency[%h fp=%0d]", v.f, v.fp), n, v.lat);
    release_out();
  endtask

  task automatic send_nosat(input logic [31:0] f, input logic [31:0] res);
    int n;
    bus0.float_in    = f;
    bus0.fixpointpos = 5'd0;
    bus0.in_valid    = 1'b1;
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus0.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("nosat_out_valid", bus0.out_valid, 1);
    check($sformatf("nosat_result[%h]", f), bus0.result, res);
    check($sformatf("nosat_overflow[%h]", f), bus0.overflow, 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;

    tbl[0]  = mk(32'h41CA0000, 5'd2,  32'h00000065, 0, 0, 0, 20);
    tbl[1]  = mk(32'hC1CA0000, 5'd2,  32'hFFFFFF9B, 0, 0, 0, 20);
    tbl[2]  = mk(32'hC1CA0000, 5'd0,  32'hFFFFFFE7, 0, 1, 0, 22);
    tbl[3]  = mk(32'h00000000, 5'd0,  32'h00000000, 0, 0, 0, 3);
    tbl[4]  = mk(32'h80000000, 5'd5,  32'h00000000, 0, 0, 0, 3);
    tbl[5]  = mk(32'h00000001, 5'd0,  32'h00000000, 0, 1, 0, 3);
    tbl[6]  = mk(32'h4F000000, 5'd0,  32'h7FFFFFFF, 1, 0, 0, 11);
    tbl[7]  = mk(32'hCF000000, 5'd0,  32'h80000000, 0, 0, 0, 11);
    tbl[8]  = mk(32'h7FC00000, 5'd0,  32'h00000000, 0, 0, 1, 3);
    tbl[9]  = mk(32'hFF800000, 5'd0,  32'h80000000, 1, 0, 0, 3);
    tbl[10] = mk(32'h3F800000, 5'd0,  32'h00000001, 0, 0, 0, 26);
    tbl[11] = mk(32'h3FC00000, 5'd0,  32'h00000001, 0, 1, 0, 26);
    tbl[12] = mk(32'h3F000000, 5'd0,  32'h00000000, 0, 1, 0, 27);
    tbl[13] = mk(32'h3E800000, 5'd0,  32'h00000000, 0, 1, 0, 3);
    tbl[14] = mk(32'hBF800000, 5'd31, 32'h80000000, 0, 0, 0, 11);
    tbl[15] = mk(32'h3F800000, 5'd31, 32'h7FFFFFFF, 1, 0, 0, 11);
    tbl[16] = mk(32'h3F800000, 5'd23, 32'h00800000, 0, 0, 0, 3);
    tbl[17] = mk(32'h40400000, 5'd30, 32'h7FFFFFFF, 1, 0, 0, 11);
    tbl[18] = mk(32'hBF000000, 5'd1,  32'hFFFFFFFF, 0, 0, 0, 26);
    tbl[19] = mk(32'h7F7FFFFF, 5'd0,  32'h7FFFFFFF, 1, 0, 0, 3);
    tbl[20] = mk(32'h80000001, 5'd0,  32'h00000000, 0, 1, 0, 3);
    tbl[21] = mk(32'h3F800000, 5'd30, 32'h40000000, 0, 0, 0, 10);
    tbl[22] = mk(32'h40000000, 5'd31, 32'h7FFFFFFF, 1, 0, 0, 3);
    tbl[23] = mk(32'hC0000000, 5'd31, 32'h80000000, 1, 0, 0, 3);

    bus.in_valid     = 1'b0;
    bus.float_in     = '0;
    bus.fixpointpos  = '0;
    bus.out_ready    = 1'b0;
    bus0.in_valid    = 1'b0;
    bus0.float_in    = '0;
    bus0.fixpointpos = '0;
    bus0.out_ready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_result", bus.result, 0);
    check("reset_flags", {bus.overflow, bus.inexact, bus.invalid}, 3'b000);
    check("reset_in_ready_low", bus.in_ready, 0);
    rst = 1'b1;
    #1 check("in_ready_after_release", bus.in_ready, 1);
    @(negedge clk);

    // Vector table
    for (int i = 0; i < NV; i++) send(tbl[i]);

    // Output held for 5 cycles with out_ready low
    v = mk(32'h41CA0000, 5'd2, 32'h00000065, 0, 0, 0, 20);
    start(v, 1'b1);
    wait_valid(n);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_result", bus.result, 32'h00000065);
    end
    release_out();

    // in_valid during SHIFT is not accepted
    v = mk(32'h3F800000, 5'd0, 32'h00000001, 0, 0, 0, 26);
    start(v, 1'b1);
    @(negedge clk);
    bus.float_in    = 32'h40000000;
    bus.fixpointpos = 5'd3;
    bus.in_valid    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("busy_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    wait_valid(n);
    release_out();
    repeat (3) @(negedge clk);
    check("no_extra_output", bus.out_valid, 0);
    check("idle_after_busy", bus.in_ready, 1);

    // Reset in the middle of SHIFT
    v = mk(32'h3F800000, 5'd0, 32'h00000001, 0, 0, 0, 26);
    start(v, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_result", bus.result, 0);
    check("midreset_in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check("midreset_in_ready_release", bus.in_ready, 1);
    @(negedge clk);
    repeat (30) @(negedge clk);
    check("midreset_no_output", bus.out_valid, 0);
    send(mk(32'hC1CA0000, 5'd2, 32'hFFFFFF9B, 0, 0, 0, 20));

    // Non-saturating instance
    send_nosat(32'h4F000000, 32'h00000000);
    send_nosat(32'hFF800000, 32'h00000000);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
